riscv_perf_monitor: RTL and testbench
=====================================

Name: riscv_perf_monitor

Overview:
- Hardware performance-monitor unit for the dual-issue core.
- Consumes per-cycle issue and branch-predictor event strobes from the pipeline.
- Accumulates them in 64-bit counters and exposes them through a 32-bit register read/write port.
- Lets test programs and bench/debug logic read IPC, dual-issue and prediction statistics from hardware instead of probing hierarchy.

Parameters:
- CNT_WIDTH, 64, width of each event counter; must be 33..64.
- EN_RESET, 1, value of the global count-enable bit after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid_0  in  1  slot-0 instruction issued this cycle.
- issue_valid_1  in  1  slot-1 instruction issued this cycle.
- bp_resolve  in  1  a predicted branch resolved this cycle.
- bp_correct  in  1  qualifies bp_resolve: 1 = prediction correct.
- reg_addr  in  4  register index.
- reg_rd  in  1  read strobe.
- reg_wr  in  1  write strobe.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data.
- reg_rvalid  out  1  read data valid.
- ovf_irq  out  1  OR of all sticky overflow bits.

Behaviour:
- Reset (asynchronous, active-high rst, one clock clk):
  - all counters 0, overflow bits 0, shadow_hi 0.
  - enable = EN_RESET.
  - reg_rdata = 0, reg_rvalid = 0, ovf_irq = 0.
- Counters (index k):
  - 0 CYCLE: +1.
  - 1 INSTRET: +issue_valid_0 + issue_valid_1, i.e. +0/1/2 in one cycle.
  - 2 DUAL: +1 when both issue_valid are 1.
  - 3 BR_TOTAL: +1 on bp_resolve.
  - 4 BR_HIT: +1 on bp_resolve & bp_correct.
  - 5 BR_MISS: +1 on bp_resolve & !bp_correct.
- Counting:
  - Counters advance only while enable = 1; events while disabled are dropped.
  - Increment registers at the clk edge of the event cycle, so the count is visible to a read issued the next cycle.
- Wrap-around: counters are modulo 2^CNT_WIDTH. A carry out of the MSB (including INSTRET at all-ones - 1 with +2) sets sticky ovf[k]; the counter wraps.
- Address map:
  - 0x0-0xB: counter k lo at 2k, hi at 2k+1. hi is bits [CNT_WIDTH-1:32], zero-extended.
  - 0xC: STATUS, ovf[5:0], read-only.
  - 0xD: CTRL. bit0 enable (R/W); bit1 clear (write-1, self-clearing, reads 0); bit2 ovf_clear (write-1, self-clearing, reads 0).
  - 0xE-0xF: read 0, writes ignored.
- Read timing:
  - reg_rd in cycle N → reg_rdata valid with reg_rvalid = 1 in cycle N+1 for one cycle.
  - Back-to-back reads are allowed every cycle.
  - reg_rdata holds its last value while reg_rvalid = 0.
- Atomic 64-bit read:
  - Reading counter k lo captures counter k's upper bits (pre-increment value of that same cycle) into shadow_hi and records shadow_idx = k.
  - A subsequent hi read of k returns shadow_hi; a hi read of any other counter returns the live value.
- Writes: take effect at the edge of the strobe cycle. Writes to counter addresses are ignored (counters are read-only).
- Simultaneous events:
  - clear and an event in the same cycle: the counter becomes 0 (clear wins); ovf unaffected.
  - ovf_clear and a new overflow in the same cycle: ovf stays set (set wins).
  - reg_rd and reg_wr in the same cycle: both are performed; the read returns the pre-write value.
  - Writing enable=0 and an event in the same cycle: the event is still counted (old enable applies).
- ovf_irq: registered, equals |ovf; changes one cycle after ovf changes.
- Reset mid-operation: counters, status and any pending read are discarded immediately; no reg_rvalid is produced for a read in flight.

Decomposition:
- riscv_pkg additions:
  - perf_cnt_e enum (CYCLE, INSTRET, DUAL, BR_TOTAL, BR_HIT, BR_MISS).
  - PERF_NUM_CNT = 6.
  - Address constants PERF_ADDR_STATUS = 4'hC, PERF_ADDR_CTRL = 4'hD.
  - CTRL bit-position constants.
- Sub-module riscv_perf_counter:
  - One CNT_WIDTH counter with inputs inc[1:0], en, clr.
  - Outputs count and a carry pulse.
  - Instantiated six times; the top owns enable, ovf, shadow and the register port.

Test Plan:
- Reset, then 100 cycles with both issue_valid = 1 → CYCLE = 100, INSTRET = 200, DUAL = 100; read of addr 0x2 returns 200 with reg_rvalid exactly one cycle after reg_rd.
- 10 bp_resolve pulses, 7 with bp_correct = 1 → BR_TOTAL = 10, BR_HIT = 7, BR_MISS = 3; CYCLE unaffected by branch strobes.
- Write CTRL = 0, drive 50 issue cycles, write CTRL = 1 → INSTRET unchanged across the disabled window; event in the same cycle as the disable write is counted.
- Force INSTRET to 2^64 - 1 (bench backdoor) and issue dual → INSTRET = 1, STATUS = 0x02, ovf_irq = 1 next cycle; write CTRL = 0x4 → STATUS = 0, ovf_irq = 0.
- CYCLE at 0x0000_0000_FFFF_FFFF: read lo (gets 0xFFFFFFFF), then read hi 3 cycles later → hi returns 0x0 (shadow), not 0x1; an intervening hi read of counter 1 returns live value.
- Write CTRL = 0x3 while issue_valid_0 = 1 → all counters 0 the next cycle; assert rst mid-read → reg_rvalid stays 0 and reg_rdata = 0.

Source files
------------

// File: rtl/riscv_perf_monitor_pkg.sv
// Shared definitions for the performance-monitor unit: counter indices,
// register address constants and CTRL bit positions.
package riscv_perf_monitor_pkg;

  typedef enum logic [2:0] {
    CYCLE    = 3'd0,
    INSTRET  = 3'd1,
    DUAL     = 3'd2,
    BR_TOTAL = 3'd3,
    BR_HIT   = 3'd4,
    BR_MISS  = 3'd5
  } perf_cnt_e;

  localparam int PERF_NUM_CNT = 6;

  localparam logic [3:0] PERF_ADDR_STATUS = 4'hC;
  localparam logic [3:0] PERF_ADDR_CTRL   = 4'hD;

  localparam int PERF_CTRL_EN      = 0;
  localparam int PERF_CTRL_CLR     = 1;
  localparam int PERF_CTRL_OVF_CLR = 2;

endpackage

// File: rtl/riscv_perf_counter.sv
// One wrapping event counter: adds inc (0..2) per enabled cycle and pulses
// carry when the addition runs out of the MSB.
module riscv_perf_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           inc,
  input  logic                 en,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 carry
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH:0]   sum;

  assign sum   = {1'b0, count_q} + {{(CNT_WIDTH-1){1'b0}}, inc};
  // A clear in the same cycle discards the event, so it cannot overflow either.
  assign carry = en & ~clr & sum[CNT_WIDTH];
  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/riscv_perf_monitor.sv
// Performance monitor: six event counters behind a 32-bit register port with
// atomic hi/lo reads via a shadow register and sticky overflow interrupt.
module riscv_perf_monitor
  import riscv_perf_monitor_pkg::*;
#(
  parameter int   CNT_WIDTH = 64,
  parameter logic EN_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_0,
  input  logic        issue_valid_1,
  input  logic        bp_resolve,
  input  logic        bp_correct,
  input  logic [3:0]  reg_addr,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        ovf_irq
);

  logic [1:0]              inc    [PERF_NUM_CNT];
  logic [CNT_WIDTH-1:0]    cnt    [PERF_NUM_CNT];
  logic [31:0]             cnt_hi [PERF_NUM_CNT];
  logic [PERF_NUM_CNT-1:0] carry;

  logic                    enable_q;
  logic [PERF_NUM_CNT-1:0] ovf_q;
  logic [31:0]             shadow_hi;
  logic [2:0]              shadow_idx;
  logic                    shadow_vld;

  logic        ctrl_wr;
  logic        cnt_clr;
  logic        ovf_clr;
  logic        is_cnt_addr;
  logic [2:0]  cnt_sel;
  logic [31:0] rd_mux;
  logic        wdata_unused;

  assign inc[CYCLE]    = 2'd1;
  assign inc[INSTRET]  = {1'b0, issue_valid_0} + {1'b0, issue_valid_1};
  assign inc[DUAL]     = {1'b0, issue_valid_0 & issue_valid_1};
  assign inc[BR_TOTAL] = {1'b0, bp_resolve};
  assign inc[BR_HIT]   = {1'b0, bp_resolve & bp_correct};
  assign inc[BR_MISS]  = {1'b0, bp_resolve & ~bp_correct};

  assign ctrl_wr      = reg_wr && (reg_addr == PERF_ADDR_CTRL);
  assign cnt_clr      = ctrl_wr && reg_wdata[PERF_CTRL_CLR];
  assign ovf_clr      = ctrl_wr && reg_wdata[PERF_CTRL_OVF_CLR];
  assign wdata_unused = ^reg_wdata[31:3];

  // Counters see the enable from before this cycle's CTRL write.
  for (genvar g = 0; g < PERF_NUM_CNT; g++) begin : g_cnt
    riscv_perf_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .en    (enable_q),
      .clr   (cnt_clr),
      .count (cnt[g]),
      .carry (carry[g])
    );
    assign cnt_hi[g] = 32'(cnt[g][CNT_WIDTH-1:32]);
  end

  assign cnt_sel     = reg_addr[3:1];
  assign is_cnt_addr = (reg_addr < PERF_ADDR_STATUS);

  always_comb begin
    rd_mux = '0;
    if (is_cnt_addr) begin
      if (!reg_addr[0]) begin
        rd_mux = cnt[cnt_sel][31:0];
      end else if (shadow_vld && (shadow_idx == cnt_sel)) begin
        rd_mux = shadow_hi;
      end else begin
        rd_mux = cnt_hi[cnt_sel];
      end
    end else if (reg_addr == PERF_ADDR_STATUS) begin
      rd_mux = {{(32-PERF_NUM_CNT){1'b0}}, ovf_q};
    end else if (reg_addr == PERF_ADDR_CTRL) begin
      rd_mux = {31'b0, enable_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= EN_RESET;
      ovf_q      <= '0;
      ovf_irq    <= 1'b0;
      shadow_hi  <= '0;
      shadow_idx <= '0;
      shadow_vld <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= reg_wdata[PERF_CTRL_EN];
      end
      // A fresh carry beats a simultaneous ovf_clear.
      ovf_q   <= (ovf_clr ? '0 : ovf_q) | carry;
      ovf_irq <= |ovf_q;
      if (reg_rd && is_cnt_addr && !reg_addr[0]) begin
        shadow_hi  <= cnt_hi[cnt_sel];
        shadow_idx <= cnt_sel;
        shadow_vld <= 1'b1;
      end
    end
  end

  // Read handshake: reg_rd is a single-cycle strobe with no backpressure;
  // reg_rvalid pulses exactly one cycle later and reg_rdata holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) begin
        reg_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Directed bench for riscv_perf_monitor: inputs change just after each
// falling edge, outputs are checked at the following falling edge.
module tb_riscv_perf_monitor;

  logic        clk;
  logic        rst;
  logic        issue_valid_0;
  logic        issue_valid_1;
  logic        bp_resolve;
  logic        bp_correct;
  logic [3:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        ovf_irq;

  int vectors;
  int miscompares;

  riscv_perf_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_0 (issue_valid_0),
    .issue_valid_1 (issue_valid_1),
    .bp_resolve    (bp_resolve),
    .bp_correct    (bp_correct),
    .reg_addr      (reg_addr),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_rvalid    (reg_rvalid),
    .ovf_irq       (ovf_irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: each is entered just after a falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    reg_rd   = 1'b1;
    reg_addr = a;
    step();
    reg_rd = 1'b0;
    check({tag, "_rvalid"}, {31'b0, reg_rvalid}, 32'd1);
    check(tag, reg_rdata, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    step();
    reg_wr = 1'b0;
  endtask

  logic [9:0] hit_pat;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    issue_valid_0 = 1'b0;
    issue_valid_1 = 1'b0;
    bp_resolve    = 1'b0;
    bp_correct    = 1'b0;
    reg_addr      = 4'h0;
    reg_rd        = 1'b0;
    reg_wr        = 1'b0;
    reg_wdata     = 32'h0;
    hit_pat       = 10'b1011011011;

    // reset state
    repeat (3) step();
    check("rst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_irq", {31'b0, ovf_irq}, 32'd0);
    rst = 1'b0;
    step();
    rd(4'hC, 32'h0, "rst_status");
    rd(4'hD, 32'h1, "rst_ctrl");

    // 100 dual-issue cycles; the last one also writes enable=0 and still counts
    issue_valid_0 = 1'b1;
    issue_valid_1 = 1'b1;
    wr(4'hD, 32'h3);
    repeat (99) step();
    wr(4'hD, 32'h0);
    issue_valid_0 = 1'b0;
    issue_valid_1 = 1'b0;
    rd(4'h0, 32'd100, "cycle_lo");
    step();
    check("rvalid_one_cycle", {31'b0, reg_rvalid}, 32'd0);
    rd(4'h2, 32'd200, "instret_lo");
    rd(4'h3, 32'd0, "instret_hi");
    rd(4'h4, 32'd100, "dual_lo");

    // branch events: 10 resolves, 7 correct
    wr(4'hD, 32'h3);
    for (int i = 0; i < 10; i++) begin
      bp_resolve = 1'b1;
      bp_correct = hit_pat[i];
      if (i == 9) wr(4'hD, 32'h0);
      else step();
    end
    bp_resolve = 1'b0;
    bp_correct = 1'b0;
    rd(4'h0, 32'd10, "br_cycle");
    rd(4'h6, 32'd10, "br_total");
    rd(4'h8, 32'd7, "br_hit");
    rd(4'hA, 32'd3, "br_miss");
    rd(4'h2, 32'd0, "br_instret");

    // disabled window
    wr(4'hD, 32'h1);
    issue_valid_0 = 1'b1;
    repeat (4) step();
    wr(4'hD, 32'h0);
    issue_valid_1 = 1'b1;
    repeat (50) step();
    wr(4'hD, 32'h1);
    issue_valid_0 = 1'b0;
    issue_valid_1 = 1'b0;
    rd(4'h2, 32'd5, "dis_instret");
    rd(4'h4, 32'd0, "dis_dual");
    rd(4'hD, 32'd1, "dis_ctrl");

    // INSTRET overflow by +2 from all-ones
    dut.g_cnt[1].u_cnt.count_q = '1;
    issue_valid_0 = 1'b1;
    issue_valid_1 = 1'b1;
    step();
    issue_valid_0 = 1'b0;
    issue_valid_1 = 1'b0;
    check("ovf_irq_lag", {31'b0, ovf_irq}, 32'd0);
    rd(4'hC, 32'h02, "ovf_status");
    check("ovf_irq_set", {31'b0, ovf_irq}, 32'd1);
    rd(4'h2, 32'd1, "ovf_instret");
    wr(4'hD, 32'h4);
    check("ovf_irq_hold", {31'b0, ovf_irq}, 32'd1);
    rd(4'hC, 32'h0, "ovf_cleared");
    check("ovf_irq_clr", {31'b0, ovf_irq}, 32'd0);
    rd(4'hD, 32'h0, "ovf_ctrl");

    // overflow set wins against ovf_clear in the same cycle
    wr(4'hD, 32'h1);
    dut.g_cnt[3].u_cnt.count_q = '1;
    bp_resolve = 1'b1;
    bp_correct = 1'b1;
    wr(4'hD, 32'h5);
    bp_resolve = 1'b0;
    bp_correct = 1'b0;
    rd(4'hC, 32'h08, "set_wins");
    rd(4'h6, 32'd0, "br_total_wrap");
    rd(4'h8, 32'd8, "br_hit_after");

    // atomic hi/lo via shadow
    dut.g_cnt[0].u_cnt.count_q = 64'h0000_0000_FFFF_FFFF;
    dut.g_cnt[1].u_cnt.count_q = 64'h0000_0005_0000_0003;
    rd(4'h0, 32'hFFFF_FFFF, "shadow_lo");
    rd(4'h3, 32'd5, "live_hi_other");
    step();
    rd(4'h1, 32'd0, "shadow_hi");
    rd(4'h2, 32'd3, "instret_lo2");
    rd(4'h1, 32'd1, "cycle_hi_live");
    rd(4'h3, 32'd5, "instret_hi_shadow");

    // clear beats an event; read+write same cycle returns the old value
    issue_valid_0 = 1'b1;
    wr(4'hD, 32'h3);
    issue_valid_0 = 1'b0;
    reg_wr    = 1'b1;
    reg_wdata = 32'h0;
    rd(4'hD, 32'd1, "rd_wr_same");
    reg_wr = 1'b0;
    rd(4'h0, 32'd1, "clr_cycle");
    rd(4'h2, 32'd0, "clr_instret");
    rd(4'h4, 32'd0, "clr_dual");
    rd(4'hC, 32'h08, "clr_keeps_ovf");
    wr(4'hE, 32'hFFFF_FFFF);
    rd(4'hE, 32'h0, "addr_e");
    rd(4'hD, 32'h0, "ctrl_after_e");
    rd(4'h0, 32'd1, "cycle_frozen");
    step();
    check("hold_rvalid", {31'b0, reg_rvalid}, 32'd0);
    check("hold_rdata", reg_rdata, 32'd1);

    // reset with a read in flight
    reg_rd   = 1'b1;
    reg_addr = 4'h0;
    #2 rst = 1'b1;
    step();
    reg_rd = 1'b0;
    check("mid_rst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    check("mid_rst_rdata", reg_rdata, 32'd0);
    check("mid_rst_irq", {31'b0, ovf_irq}, 32'd0);
    rst = 1'b0;
    step();
    rd(4'hD, 32'd1, "post_rst_ctrl");
    rd(4'hC, 32'h0, "post_rst_status");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
